// File: rtl/occupancy_gate_ctrl.sv
// Doorway direction sequencer: debounces the outer/inner beams and turns completed
// crossings into single-cycle entry/exit pulses for the occupancy tracker.
module occupancy_gate_ctrl #(
   parameter int DEBOUNCE = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic beam_outer,
   input  logic beam_inner,
   input  logic max_capacity,
   output logic entry_pulse,
   output logic exit_pulse,
   output logic deny_pulse,
   output logic fault_pulse,
   output logic gate_lock,
   output logic busy
);

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE, E1, E2, E3, X1, X2, X3, DENY, CLEAR
   } state_t;

   logic [1:0] raw;
   logic [1:0] filt;

   assign raw = {beam_outer, beam_inner};

   // Bit 1 is the outer beam, bit 0 the inner beam.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
         logic [3:0] cnt_reg;
         logic       filt_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg  <= '0;
               filt_reg <= 1'b0;
            end else if (raw[gi] != filt_reg) begin
               if (cnt_reg == DB_LAST) begin
                  filt_reg <= raw[gi];
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end else begin
               cnt_reg <= '0;
            end
         end

         assign filt[gi] = filt_reg;
      end
   endgenerate

   state_t     state_reg, state_next;
   logic [7:0] timer_reg, timer_next;
   logic       entry_next, exit_next, deny_next, fault_next;
   logic       in_crossing;

   assign in_crossing = (state_reg != IDLE) && (state_reg != DENY) && (state_reg != CLEAR);

   always_comb begin
      state_next = state_reg;
      entry_next = 1'b0;
      exit_next  = 1'b0;
      deny_next  = 1'b0;
      fault_next = 1'b0;
      if (in_crossing && (timer_reg == TO_LAST)) begin
         state_next = CLEAR;
         fault_next = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               case (filt)
                  2'b10: begin
                     if (max_capacity) begin
                        state_next = DENY;
                        deny_next  = 1'b1;
                     end else begin
                        state_next = E1;
                     end
                  end
                  2'b01: state_next = X1;
                  2'b11: begin
                     state_next = CLEAR;
                     fault_next = 1'b1;
                  end
                  default: state_next = IDLE;
               endcase
            end
            E1: begin
               case (filt)
                  2'b11:   state_next = E2;
                  2'b01:   state_next = E3;
                  2'b00:   state_next = IDLE;
                  default: state_next = E1;
               endcase
            end
            E2: begin
               case (filt)
                  2'b01:   state_next = E3;
                  2'b10:   state_next = E1;
                  2'b00:   state_next = IDLE;
                  default: state_next = E2;
               endcase
            end
            E3: begin
               case (filt)
                  2'b00: begin
                     state_next = IDLE;
                     entry_next = 1'b1;
                  end
                  2'b11:   state_next = E2;
                  2'b10:   state_next = E1;
                  default: state_next = E3;
               endcase
            end
            X1: begin
               case (filt)
                  2'b11:   state_next = X2;
                  2'b10:   state_next = X3;
                  2'b00:   state_next = IDLE;
                  default: state_next = X1;
               endcase
            end
            X2: begin
               case (filt)
                  2'b10:   state_next = X3;
                  2'b01:   state_next = X1;
                  2'b00:   state_next = IDLE;
                  default: state_next = X2;
               endcase
            end
            X3: begin
               case (filt)
                  2'b00: begin
                     state_next = IDLE;
                     exit_next  = 1'b1;
                  end
                  2'b11:   state_next = X2;
                  2'b01:   state_next = X1;
                  default: state_next = X3;
               endcase
            end
            DENY, CLEAR: begin
               if (filt == 2'b00) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Timer only runs while a crossing sits in one state.
   always_comb begin
      if ((state_next != state_reg) || !in_crossing) timer_next = '0;
      else                                           timer_next = timer_reg + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         entry_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         deny_pulse  <= 1'b0;
         fault_pulse <= 1'b0;
         gate_lock   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         entry_pulse <= entry_next;
         exit_pulse  <= exit_next;
         deny_pulse  <= deny_next;
         fault_pulse <= fault_next;
         gate_lock   <= max_capacity;
         busy        <= (state_reg != IDLE);
      end
   end

endmodule
